// File: rtl/cmd_parser.sv
// Byte-stream command parser: short commands (bit7=0) execute directly, long commands
// (bit7=1) collect a 4-byte little-endian argument. Optional timeout: CMD_PARSER_TIMEOUT_EN.
module cmd_parser #(
    parameter int TMO_CYCLES = 100000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [7:0]  opcode,
    output logic [31:0] config_data,
    output logic        execute,
    output logic        abort
);

    // Handshake: a byte moves when rx_valid && rx_ready on a rising sys_clk edge;
    // rx_ready is low in EXEC and while sys_rst_n is low, high otherwise.
    typedef enum logic [1:0] {IDLE, ARG, EXEC} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [7:0]  opcode_nxt;
    logic [31:0] config_nxt;
    logic        accept;
    logic        tmo_expire;

    assign rx_ready = sys_rst_n && (state != EXEC);
    assign accept   = rx_valid && rx_ready;
    assign execute  = (state == EXEC);

`ifdef CMD_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;
    logic          abort_q;

    // An accepted byte on the expiry cycle wins over the timeout.
    assign tmo_expire = (state == ARG) && !accept && (tmo_cnt == TMO_LAST);
    assign abort      = abort_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tmo_cnt <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= tmo_expire;
            if (state != ARG || accept)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_expire = 1'b0;
    assign abort      = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            opcode      <= 8'h00;
            config_data <= 32'h0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            opcode      <= opcode_nxt;
            config_data <= config_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        opcode_nxt = opcode;
        config_nxt = config_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    opcode_nxt = rx_data;
                    config_nxt = 32'h0;
                    cnt_nxt    = 2'd0;
                    state_nxt  = rx_data[7] ? ARG : EXEC;
                end
            end
            ARG: begin
                if (accept) begin
                    config_nxt[{cnt, 3'b000} +: 8] = rx_data;
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3)
                        state_nxt = EXEC;
                end else if (tmo_expire) begin
                    state_nxt = IDLE;
                end
            end
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cmd_parser.sv
// Self-checking bench for cmd_parser: scoreboard of expected {opcode, config_data}
// popped on every execute, plus scenario tasks with inline checks.
module tb_cmd_parser;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic [7:0]  opcode;
    logic [31:0] config_data;
    logic        execute;
    logic        abort;

    int total = 0;
    int bad = 0;
    int exec_cnt = 0;
    int abort_cnt = 0;
    logic [39:0] exp_q[$];

    cmd_parser #(.TMO_CYCLES(16)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .opcode      (opcode),
        .config_data (config_data),
        .execute     (execute),
        .abort       (abort)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    always @(negedge sys_clk) begin
        if (execute) begin
            logic [39:0] e;
            exec_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_execute: got op=%02h cfg=%08h, required no execute",
                         opcode, config_data);
            end else begin
                e = exp_q.pop_front();
                if ({opcode, config_data} !== e) begin
                    bad++;
                    $display("FAIL sb_execute_data: got op=%02h cfg=%08h, required op=%02h cfg=%08h",
                             opcode, config_data, e[39:32], e[31:0]);
                end
            end
        end
        if (abort) abort_cnt++;
        if (execute && abort) begin
            total++;
            bad++;
            $display("FAIL sb_exec_abort_overlap: execute=1 abort=1, required not both");
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit keep);
        int guard = 0;
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 50) begin
            @(negedge sys_clk);
            guard++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL send_ready_timeout: rx_ready=%0b, required 1 within 50 cycles", rx_ready);
        end
        @(posedge sys_clk);
        #1;
        if (!keep) rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        total++;
        if (rx_ready !== 1'b0 || execute !== 1'b0 || abort !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes: ready=%0b exec=%0b abort=%0b, required 0 0 0",
                     rx_ready, execute, abort);
        end
        total++;
        if (opcode !== 8'h00 || config_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: op=%02h cfg=%08h, required 00 00000000", opcode, config_data);
        end
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        total++;
        if (rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: rx_ready=%0b, required 1", rx_ready);
        end
    endtask

    task automatic test_short();
        exp_q.push_back({8'h02, 32'h0});
        send_byte(8'h02, 1'b0);
        total++;
        if (execute !== 1'b1 || rx_ready !== 1'b0 || opcode !== 8'h02 || config_data !== 32'h0) begin
            bad++;
            $display("FAIL short_exec: exec=%0b ready=%0b op=%02h cfg=%08h, required 1 0 02 00000000",
                     execute, rx_ready, opcode, config_data);
        end
        @(posedge sys_clk);
        #1;
        total++;
        if (execute !== 1'b0 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL short_after: exec=%0b ready=%0b, required 0 1", execute, rx_ready);
        end
    endtask

    task automatic test_long();
        int e0 = exec_cnt;
        send_byte(8'hC0, 1'b0);
        total++;
        if (opcode !== 8'hC0 || config_data !== 32'h0 || execute !== 1'b0) begin
            bad++;
            $display("FAIL long_header: op=%02h cfg=%08h exec=%0b, required C0 00000000 0",
                     opcode, config_data, execute);
        end
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b0);
        total++;
        if (config_data !== 32'h00345678 || execute !== 1'b0) begin
            bad++;
            $display("FAIL long_partial: cfg=%08h exec=%0b, required 00345678 0", config_data, execute);
        end
        exp_q.push_back({8'hC0, 32'h12345678});
        send_byte(8'h12, 1'b0);
        total++;
        if (execute !== 1'b1) begin
            bad++;
            $display("FAIL long_exec_latency: exec=%0b, required 1", execute);
        end
        repeat (3) @(posedge sys_clk);
        #1;
        total++;
        if (exec_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL long_exec_count: got %0d, required 1", exec_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6];
        int e0 = exec_cnt;
        seq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({seq[i], 32'h0});
            send_byte(seq[i], (i != 5));
            total++;
            if (rx_ready !== 1'b0 || execute !== 1'b1) begin
                bad++;
                $display("FAIL b2b_stall[%0d]: ready=%0b exec=%0b, required 0 1", i, rx_ready, execute);
            end
        end
        repeat (2) @(posedge sys_clk);
        #1;
        total++;
        if (exec_cnt - e0 !== 6) begin
            bad++;
            $display("FAIL b2b_exec_count: got %0d, required 6", exec_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        int a0 = abort_cnt;
        int e0 = exec_cnt;
        send_byte(8'h81, 1'b0);
        send_byte(8'hAA, 1'b0);
`ifdef CMD_PARSER_TIMEOUT_EN
        repeat (15) @(posedge sys_clk);
        #1;
        total++;
        if (abort !== 1'b0) begin
            bad++;
            $display("FAIL tmo_early: abort=%0b at 15 cycles, required 0", abort);
        end
        @(posedge sys_clk);
        #1;
        total++;
        if (abort !== 1'b1 || execute !== 1'b0) begin
            bad++;
            $display("FAIL tmo_abort: abort=%0b exec=%0b at 16 cycles, required 1 0", abort, execute);
        end
        total++;
        if (opcode !== 8'h81 || config_data !== 32'h000000AA) begin
            bad++;
            $display("FAIL tmo_retain: op=%02h cfg=%08h, required 81 000000AA", opcode, config_data);
        end
        @(posedge sys_clk);
        #1;
        total++;
        if (abort !== 1'b0 || abort_cnt - a0 !== 1) begin
            bad++;
            $display("FAIL tmo_pulse: abort=%0b count=%0d, required 0 1", abort, abort_cnt - a0);
        end
        exp_q.push_back({8'h02, 32'h0});
        send_byte(8'h02, 1'b0);
`else
        repeat (40) @(posedge sys_clk);
        #1;
        total++;
        if (abort_cnt - a0 !== 0 || execute !== 1'b0) begin
            bad++;
            $display("FAIL notmo_abort: aborts=%0d exec=%0b, required 0 0", abort_cnt - a0, execute);
        end
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        exp_q.push_back({8'h81, 32'hDDCCBBAA});
        send_byte(8'hDD, 1'b0);
`endif
        repeat (2) @(posedge sys_clk);
        #1;
        total++;
        if (exec_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL tmo_followup_exec: got %0d, required 1", exec_cnt - e0);
        end
    endtask

    task automatic test_expiry_race();
        int a0 = abort_cnt;
        send_byte(8'h85, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (15) @(posedge sys_clk);
        send_byte(8'h02, 1'b0);
        repeat (15) @(posedge sys_clk);
        send_byte(8'h03, 1'b0);
        exp_q.push_back({8'h85, 32'h04030201});
        send_byte(8'h04, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        total++;
        if (abort_cnt - a0 !== 0) begin
            bad++;
            $display("FAIL race_abort: aborts=%0d, required 0", abort_cnt - a0);
        end
    endtask

    task automatic test_reset_mid();
        int e0 = exec_cnt;
        send_byte(8'h82, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        total++;
        if (opcode !== 8'h00 || config_data !== 32'h0 || execute !== 1'b0 || abort !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_state: op=%02h cfg=%08h exec=%0b abort=%0b, required 00 00000000 0 0",
                     opcode, config_data, execute, abort);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        exp_q.push_back({8'h11, 32'h0});
        send_byte(8'h11, 1'b0);
        total++;
        if (execute !== 1'b1 || opcode !== 8'h11) begin
            bad++;
            $display("FAIL rstmid_short: exec=%0b op=%02h, required 1 11", execute, opcode);
        end
        repeat (2) @(posedge sys_clk);
        #1;
        total++;
        if (exec_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL rstmid_exec_count: got %0d, required 1", exec_cnt - e0);
        end
    endtask

    task automatic test_random();
        int e0 = exec_cnt;
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0]  op = 8'($urandom_range(0, 255));
            logic [31:0] arg = $urandom;
            if (op[7]) begin
                send_byte(op, 1'b0);
                for (int k = 0; k < 3; k++) begin
                    repeat ($urandom_range(0, 3)) @(posedge sys_clk);
                    send_byte(arg[8*k +: 8], 1'b0);
                end
                exp_q.push_back({op, arg});
                send_byte(arg[31:24], 1'b0);
            end else begin
                exp_q.push_back({op, 32'h0});
                send_byte(op, 1'b0);
            end
            n++;
            repeat ($urandom_range(0, 3)) @(posedge sys_clk);
        end
        repeat (2) @(posedge sys_clk);
        #1;
        total++;
        if (exec_cnt - e0 !== n) begin
            bad++;
            $display("FAIL random_exec_count: got %0d, required %0d", exec_cnt - e0, n);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_back_to_back();
        test_timeout();
        test_expiry_race();
        test_reset_mid();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d expected executes pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter TMO_CYCLES, default 100000: inter-byte timeout, in sys_clk cycles, for a partially received long command.
REQ-002 Port sys_clk, input, 1: the single clock; all logic rises on its positive edge.
REQ-003 Port sys_rst_n, input, 1: reset, synchronous, active-low.
REQ-004 Port rx_valid, input, 1: a received serial byte is present on rx_data.
REQ-005 Port rx_data, input, 8: received byte.
REQ-006 Port rx_ready, output, 1: parser accepts the byte; a transfer occurs when rx_valid && rx_ready.
REQ-007 Port opcode, output, 8: decoded command byte, held stable between executes.
REQ-008 Port config_data, output, 32: long-command argument, held stable between executes.
REQ-009 Port execute, output, 1: one-cycle strobe meaning opcode/config_data are valid.
REQ-010 Port abort, output, 1: one-cycle strobe meaning a partial long command was discarded.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ARG and EXEC.
REQ-012 IDLE, byte accepted with bit7=0 (short command): the byte SHALL be latched into opcode, config_data SHALL be cleared to 0, and the FSM SHALL go to EXEC.
REQ-013 IDLE, byte accepted with bit7=1 (long command): the byte SHALL be latched into opcode, the byte counter SHALL be set to 0, config_data SHALL be cleared, and the FSM SHALL go to ARG.
REQ-014 ARG: each accepted byte SHALL be written to config_data[8*cnt+7 : 8*cnt] (little-endian, first byte is LSB), and cnt SHALL increment.
- The 4th byte (cnt=3) SHALL move the FSM to EXEC.
REQ-015 EXEC: execute SHALL be 1 for exactly this one cycle, then the FSM SHALL go to IDLE.
- Latency: execute is asserted the cycle after the final byte is accepted.
REQ-016 rx_ready SHALL be 1 in IDLE and ARG and 0 in EXEC, so back-to-back bytes stall exactly one cycle per command.
REQ-017 opcode and config_data SHALL change only on accepted bytes and SHALL NOT change while execute=1.
REQ-018 rx_valid=0 in any state SHALL cause no state or data change, apart from the timeout counter.
REQ-019 The byte counter SHALL be 2 bits wide; a wrap past 3 SHALL be unreachable, because cnt=3 exits ARG.
REQ-020 Opcode 0x00 (SUMP reset) SHALL be treated as a normal short command; repeated 0x00 bytes SHALL each produce an execute.
REQ-021 abort SHALL be 0 whenever execute is 1; both SHALL never assert in the same cycle.

Reset
REQ-022 When sys_rst_n=0 at a clock edge, the parser SHALL enter IDLE with:
- opcode=0x00, config_data=0, cnt=0, timeout counter=0;
- execute=0, abort=0;
- rx_ready=0 during the reset cycle, and 1 from the first cycle after release.
REQ-023 Reset asserted mid-ARG or in EXEC SHALL discard the partial command with no execute and no abort strobe.

Configuration
REQ-024 Macro CMD_PARSER_TIMEOUT_EN SHALL control the inter-byte timeout.
- Defined: in ARG, a counter of width $clog2(TMO_CYCLES+1) SHALL increment each cycle with no accepted byte, and SHALL clear on every accepted byte and on ARG entry.
- Defined: when the counter reaches TMO_CYCLES-1 with no byte accepted that cycle, the FSM SHALL go to IDLE, abort SHALL pulse one cycle, and opcode/config_data SHALL retain their partial values with no execute.
- Defined: a byte accepted in the same cycle as expiry SHALL win; the counter clears and no abort is raised.
- Not defined: no counter SHALL exist, abort SHALL be tied to 0, and ARG SHALL wait indefinitely.

Verification
REQ-025 Short command: byte 0x02 -> execute one cycle later with opcode=0x02, config_data=0x00000000; rx_ready=0 in that cycle only.
REQ-026 Long command: bytes 0xC0,0x78,0x56,0x34,0x12 -> exactly one execute with opcode=0xC0, config_data=0x12345678; no execute on intermediate bytes.
REQ-027 Back-to-back traffic: 0x00,0x00,0x00,0x00,0x00,0x01 with rx_valid held high -> six execute pulses, each followed by a one-cycle rx_ready=0 stall.
REQ-028 Timeout (macro defined, TMO_CYCLES=16): bytes 0x81,0xAA then idle -> abort pulse 16 cycles after 0xAA, no execute; a following 0x02 -> normal short execute.
REQ-029 Reset mid-command: 0x82,0x11,0x22, then sys_rst_n=0 for 1 cycle, then 0x11 -> no execute until a new command; after the reset opcode=0x00; the 0x11 alone is a short command with execute and opcode=0x11.
REQ-030 Expiry race (macro defined, TMO_CYCLES=16): byte accepted exactly on the expiry cycle -> no abort, the command completes normally on its remaining bytes.
